rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//   Staged reset sequencer for the DUT and its sub-blocks.
//   - Holds all downstream reset domains after rst falls, then releases them one at a time, in order, with a fixed gap.
//   - Waits a settle period, then raises init_done.
//   - Accepts a soft-reset request that replays the same sequence.
//   - Replaces hand-coded reset/settle delays in benches with one synthesizable controller.
// PARAMETERS
//   NUM_STAGES     4    number of staged reset outputs (>=1)
//   ASSERT_CYCLES  2    cycles all stages stay asserted after sequence start (>=1)
//   STAGE_GAP      4    cycles between consecutive stage releases (>=1)
//   SETTLE_CYCLES  20   cycles from last stage release to init_done (>=0)
// PORTS
//   clk          in   1           single clock; all logic on rising edge
//   rst          in   1           synchronous, active-high reset
//   sw_rst_req   in   1           soft-reset request, sampled each edge
//   stage_rst_o  out  NUM_STAGES  per-domain reset, active-high; bit 0 released first
//   sw_rst_ack   out  1           one-cycle pulse: sw_rst_req accepted
//   busy         out  1           1 while sequence in progress
//   init_done    out  1           1 once all stages released and settled
// BEHAVIOUR
//   Interface: one clock, clk; reset rst is synchronous and active-high.
//   Reset values (any edge sampling rst=1):
//     - stage_rst_o = all 1s, sw_rst_ack = 0, busy = 1, init_done = 0
//     - state = ASSERT, counter = 0, stage index = 0
//   Outputs are registered. No combinational input-to-output paths.
//   Timing notation: Ek = k-th rising edge after sequence start.
//     - After reset, E1 = first edge sampling rst=0.
//   Release schedule:
//     - stage_rst_o[i] falls at edge E(ASSERT_CYCLES + i*STAGE_GAP).
//     - init_done rises and busy falls at edge E(ASSERT_CYCLES + (NUM_STAGES-1)*STAGE_GAP + SETTLE_CYCLES).
//     - SETTLE_CYCLES=0: init_done rises on the same edge as the last release.
//   FSM states:
//     - ASSERT:  count ASSERT_CYCLES, release stage 0 -> RELEASE (NUM_STAGES=1: -> SETTLE, or DONE if SETTLE_CYCLES=0)
//     - RELEASE: count STAGE_GAP per stage; after last stage -> SETTLE (or DONE if SETTLE_CYCLES=0)
//     - SETTLE:  count SETTLE_CYCLES -> DONE
//     - DONE:    hold; accept sw_rst_req
//   stage_rst_o is always thermometer-shaped: bit i never 0 while bit i-1 is 1.
//   Soft reset:
//     - sw_rst_req=1 sampled at edge Er in DONE (rst=0) -> at Er: all stages 1, init_done 0, busy 1, sw_rst_ack 1 for exactly one cycle, state ASSERT, counter 0.
//     - Er+1 then counts as E1.
//     - sw_rst_req while busy: ignored, no ack, not queued.
//     - Held level in DONE re-triggers each time DONE is re-entered.
//   Simultaneous events:
//     - rst and sw_rst_req on the same edge: rst wins, sw_rst_ack stays 0.
//   rst mid-sequence (any state): full reset values at that edge; sequence restarts from E1.
//   Width rules:
//     - Internal counter wide enough for max(ASSERT_CYCLES, STAGE_GAP, SETTLE_CYCLES); never wraps.
//     - Stage index is $clog2(NUM_STAGES)+1 bits.
//   Elaboration: parameters below their minimums -> $fatal.
// TESTING (defaults unless stated)
//   1 Power-on: rst high 2 cycles, then low -> stage_rst_o falls at E2/E6/E10/E14 (0xE,0xC,0x8,0x0); init_done=1, busy=0 at E34.
//   2 One-cycle sw_rst_req in DONE at Er -> at Er: ack=1 (one cycle), stage_rst_o=0xF, init_done=0; stage0 falls Er+2; init_done at Er+34.
//   3 sw_rst_req pulsed at E8 (RELEASE) -> no ack; schedule identical to test 1.
//   4 rst high for one edge at E12 -> at that edge: stage_rst_o=0xF, init_done=0; full schedule replays from the next rst=0 edge.
//   5 rst and sw_rst_req both high in DONE -> sw_rst_ack stays 0; reset values; schedule as test 1.
//   6 NUM_STAGES=1, ASSERT_CYCLES=1, SETTLE_CYCLES=0 -> stage_rst_o falls and init_done rises together at E1.
//   All tests: assertion on the thermometer property and one-cycle sw_rst_ack width.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_ctrl
// Description : Staged reset sequencer. It releases the downstream reset
//               domains in order with a fixed gap, waits a settle period and
//               then raises init_done. A soft-reset request replays the
//               same sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int NUM_STAGES    = 4,
    parameter int ASSERT_CYCLES = 2,
    parameter int STAGE_GAP     = 4,
    parameter int SETTLE_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  sw_rst_ack,
    output logic                  busy,
    output logic                  init_done
);

    localparam int c_MAX_AG  = (ASSERT_CYCLES > STAGE_GAP) ? ASSERT_CYCLES : STAGE_GAP;
    localparam int c_MAX_CNT = (c_MAX_AG > SETTLE_CYCLES) ? c_MAX_AG : SETTLE_CYCLES;
    localparam int CNT_W     = $clog2(c_MAX_CNT + 1);
    localparam int IDX_W     = $clog2(NUM_STAGES) + 1;

    localparam int c_SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] c_ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(c_SETTLE_LAST_I);
    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(NUM_STAGES - 1);
    localparam logic             c_MULTI       = (NUM_STAGES > 1);
    localparam logic             c_HAS_SETTLE  = (SETTLE_CYCLES > 0);

    localparam logic [1:0] S_ASSERT  = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_SETTLE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    if (NUM_STAGES < 1 || ASSERT_CYCLES < 1 || STAGE_GAP < 1 || SETTLE_CYCLES < 0) begin : g_param_check
        $fatal(1, "rst_seq_ctrl: parameter below its minimum");
    end

    logic [1:0]            r_state, w_state;
    logic [CNT_W-1:0]      r_cnt,   w_cnt;
    logic [IDX_W-1:0]      r_idx,   w_idx;
    logic [NUM_STAGES-1:0] r_stage, w_stage;
    logic                  r_ack,   w_ack;
    logic                  r_busy,  w_busy;
    logic                  r_done,  w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stage <= '1;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_stage <= w_stage;
            r_ack   <= w_ack;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Releasing a stage shifts a zero in from bit 0, keeping the vector thermometer-shaped.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_stage = r_stage;
        w_ack   = 1'b0;
        w_busy  = r_busy;
        w_done  = r_done;
        case (r_state)
            S_ASSERT: begin
                if (r_cnt == c_ASSERT_LAST) begin
                    w_stage = r_stage << 1;
                    w_cnt   = '0;
                    w_idx   = r_idx + 1'b1;
                    if (c_MULTI) begin
                        w_state = S_RELEASE;
                    end else if (c_HAS_SETTLE) begin
                        w_state = S_SETTLE;
                    end else begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_stage = r_stage << 1;
                    w_cnt   = '0;
                    w_idx   = r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        if (c_HAS_SETTLE) begin
                            w_state = S_SETTLE;
                        end else begin
                            w_state = S_DONE;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state = S_DONE;
                    w_cnt   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (sw_rst_req) begin
                    w_state = S_ASSERT;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_stage = '1;
                    w_ack   = 1'b1;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                end
            end
            default: begin
                w_state = S_ASSERT;
                w_cnt   = '0;
                w_idx   = '0;
                w_stage = '1;
                w_busy  = 1'b1;
                w_done  = 1'b0;
            end
        endcase
    end

    assign stage_rst_o = r_stage;
    assign sw_rst_ack  = r_ack;
    assign busy        = r_busy;
    assign init_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_seq_ctrl
// Description : Self-checking bench for rst_seq_ctrl: directed vector table,
//               randomized run against a schedule model, NUM_STAGES=1 corner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_seq_ctrl;

    localparam int N = 4;
    localparam int A = 2;
    localparam int G = 4;
    localparam int S = 20;
    localparam int T = A + (N - 1) * G + S;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [N-1:0] stage;
    logic         ack, busy, done;

    logic         rst1 = 1'b1;
    logic         req1 = 1'b0;
    logic [0:0]   stage1;
    logic         ack1, busy1, done1;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    logic prev_ack  = 1'b0;
    logic prev_ack1 = 1'b0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(.NUM_STAGES(N), .ASSERT_CYCLES(A), .STAGE_GAP(G), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .sw_rst_req(req),
        .stage_rst_o(stage), .sw_rst_ack(ack), .busy(busy), .init_done(done)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .ASSERT_CYCLES(1), .STAGE_GAP(4), .SETTLE_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst1), .sw_rst_req(req1),
        .stage_rst_o(stage1), .sw_rst_ack(ack1), .busy(busy1), .init_done(done1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    // Thermometer shape and single-cycle ack, watched on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit bad;
            bad = 1'b0;
            for (int i = 1; i < N; i++)
                if (stage[i] == 1'b0 && stage[i-1] == 1'b1) bad = 1'b1;
            checks++;
            assert (!bad) else begin
                errors++;
                $display("FAIL thermometer actual=%0h expected=thermometer", stage);
            end
            checks++;
            assert (!(ack && prev_ack)) else begin
                errors++;
                $display("FAIL ack_width actual=2cycles expected=1cycle");
            end
            checks++;
            assert (!(ack1 && prev_ack1)) else begin
                errors++;
                $display("FAIL ack1_width actual=2cycles expected=1cycle");
            end
            prev_ack  = ack;
            prev_ack1 = ack1;
        end
    end

    typedef struct {
        string      name;
        logic       rst;
        logic       req;
        int         n;
        logic [3:0] stage;
        logic       ack;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input logic r, input logic q, input int n,
                                input logic [3:0] s, input logic a, input logic b, input logic d);
        vec_t v;
        v.name = nm; v.rst = r; v.req = q; v.n = n;
        v.stage = s; v.ack = a; v.busy = b; v.done = d;
        tbl.push_back(v);
    endfunction

    initial begin
        int k;
        bit am;
        logic r, q;
        logic [N-1:0] es;

        // power-on schedule
        add("t1_rst",   1, 0,  2, 4'hF, 0, 1, 0);
        add("t1_e1",    0, 0,  1, 4'hF, 0, 1, 0);
        add("t1_e2",    0, 0,  1, 4'hE, 0, 1, 0);
        add("t1_e5",    0, 0,  3, 4'hE, 0, 1, 0);
        add("t1_e6",    0, 0,  1, 4'hC, 0, 1, 0);
        add("t1_e10",   0, 0,  4, 4'h8, 0, 1, 0);
        add("t1_e14",   0, 0,  4, 4'h0, 0, 1, 0);
        add("t1_e33",   0, 0, 19, 4'h0, 0, 1, 0);
        add("t1_e34",   0, 0,  1, 4'h0, 0, 0, 1);
        // soft reset from DONE
        add("t2_er",    0, 1,  1, 4'hF, 1, 1, 0);
        add("t2_er1",   0, 0,  1, 4'hF, 0, 1, 0);
        add("t2_er2",   0, 0,  1, 4'hE, 0, 1, 0);
        add("t2_er33",  0, 0, 31, 4'h0, 0, 1, 0);
        add("t2_er34",  0, 0,  1, 4'h0, 0, 0, 1);
        // request while busy is dropped
        add("t3_rst",   1, 0,  1, 4'hF, 0, 1, 0);
        add("t3_e7",    0, 0,  7, 4'hC, 0, 1, 0);
        add("t3_e8req", 0, 1,  1, 4'hC, 0, 1, 0);
        add("t3_e10",   0, 0,  2, 4'h8, 0, 1, 0);
        add("t3_e34",   0, 0, 24, 4'h0, 0, 0, 1);
        // rst mid-sequence
        add("t4_rst",   1, 0,  1, 4'hF, 0, 1, 0);
        add("t4_e11",   0, 0, 11, 4'h8, 0, 1, 0);
        add("t4_rst12", 1, 0,  1, 4'hF, 0, 1, 0);
        add("t4_e2",    0, 0,  2, 4'hE, 0, 1, 0);
        add("t4_e34",   0, 0, 32, 4'h0, 0, 0, 1);
        // rst and request together
        add("t5_both",  1, 1,  1, 4'hF, 0, 1, 0);
        add("t5_e2",    0, 0,  2, 4'hE, 0, 1, 0);
        add("t5_e34",   0, 0, 32, 4'h0, 0, 0, 1);
        // held request re-triggers on each DONE entry
        add("th_er",    0, 1,  1, 4'hF, 1, 1, 0);
        add("th_run",   0, 1, 34, 4'h0, 0, 0, 1);
        add("th_re",    0, 1,  1, 4'hF, 1, 1, 0);
        add("th_end",   0, 0, 34, 4'h0, 0, 0, 1);

        foreach (tbl[j]) begin
            for (int c = 0; c < tbl[j].n; c++) tick(tbl[j].rst, tbl[j].req);
            mon_en = 1'b1;
            check({tbl[j].name, "_stage"}, 32'(stage), 32'(tbl[j].stage));
            check({tbl[j].name, "_ack"},   32'(ack),   32'(tbl[j].ack));
            check({tbl[j].name, "_busy"},  32'(busy),  32'(tbl[j].busy));
            check({tbl[j].name, "_done"},  32'(done),  32'(tbl[j].done));
        end

        // randomized run: model tracks edges since the current sequence start
        tick(1, 0);
        k  = 0;
        am = 1'b0;
        repeat (3000) begin
            r = ($urandom_range(99) == 0);
            q = ($urandom_range(3) == 0);
            tick(r, q);
            if (r) begin
                k = 0; am = 1'b0;
            end else if (k >= T && q) begin
                k = 0; am = 1'b1;
            end else begin
                am = 1'b0;
                if (k < T) k++;
            end
            for (int i = 0; i < N; i++) es[i] = (k < A + i * G);
            check("rnd_stage", 32'(stage), 32'(es));
            check("rnd_ack",   32'(ack),   32'(am));
            check("rnd_busy",  32'(busy),  32'(k < T));
            check("rnd_done",  32'(done),  32'(k >= T));
        end

        // single stage, no settle
        rst1 = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_stage", 32'(stage1), 32'd1);
        check("t6_rst_done",  32'(done1),  32'd0);
        check("t6_rst_busy",  32'(busy1),  32'd1);
        rst1 = 1'b0;
        @(posedge clk); #1;
        check("t6_e1_stage", 32'(stage1), 32'd0);
        check("t6_e1_done",  32'(done1),  32'd1);
        check("t6_e1_busy",  32'(busy1),  32'd0);
        req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        check("t6_er_stage", 32'(stage1), 32'd1);
        check("t6_er_ack",   32'(ack1),   32'd1);
        check("t6_er_done",  32'(done1),  32'd0);
        @(posedge clk); #1;
        check("t6_er1_stage", 32'(stage1), 32'd0);
        check("t6_er1_ack",   32'(ack1),   32'd0);
        check("t6_er1_done",  32'(done1),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
